mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline: consumes the execute-stage output register and produces the write-back-stage register. Loads and stores run a multi-cycle request/response handshake on the data-memory port. The block asserts `mem_busy` to the hazard unit until the access completes. It also selects write-back data (ALU result, link address or extended load data).

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_stage_align.sv | 43 ++++
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline types and constants for the memory stage
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        ebreak_en;
    logic [63:0] wb_data;
    logic [4:0]  index_rd;
    logic [63:0] pc;
    logic [31:0] instr;
  } mem_out_t;

  function automatic logic [7:0] base_mask(input logic [1:0] size);
    case (size)
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      2'b10:   return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// rtl/mem_stage_align.sv - byte-lane alignment: store mask/data and load extract/extend
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] rs2,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  output logic [63:0] ldata
);
  import mem_stage_pkg::*;

  logic [63:0] shifted;

  // Misaligned masks simply lose the bytes shifted past lane 7.
  assign wmask   = base_mask(funct3[1:0]) << off;
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    wdata = rs2;
    case (funct3[1:0])
      2'b00:   wdata = {8{rs2[7:0]}};
      2'b01:   wdata = {4{rs2[15:0]}};
      2'b10:   wdata = {2{rs2[31:0]}};
      default: wdata = rs2;
    endcase
  end

  always_comb begin
    ldata = shifted;
    case (funct3)
      F3_B:    ldata = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    ldata = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    ldata = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    ldata = shifted;
      F3_BU:   ldata = {56'd0, shifted[7:0]};
      F3_HU:   ldata = {48'd0, shifted[15:0]};
      F3_WU:   ldata = {32'd0, shifted[31:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data-memory handshake FSM and write-back register
module mem_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        update,
  input  logic        exu_valid,
  input  logic        exu_load_en,
  input  logic        exu_store_en,
  input  logic        exu_wb_en,
  input  logic        exu_wb_spc_en,
  input  logic        exu_ebreak_en,
  input  logic [2:0]  exu_funct3,
  input  logic [63:0] exu_alu_result,
  input  logic [63:0] exu_data_rs2,
  input  logic [63:0] exu_snxt_pc,
  input  logic [4:0]  exu_index_rd,
  input  logic [63:0] exu_pc,
  input  logic [31:0] exu_instr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic        mem_busy,
  output logic        mem_wb_en,
  output logic        mem_valid,
  output logic        mem_ebreak_en,
  output logic [63:0] mem_wb_data,
  output logic [4:0]  mem_index_rd,
  output logic [63:0] mem_pc,
  output logic [31:0] mem_instr
);
  import mem_stage_pkg::*;

  mem_state_e  state_q, state_d;
  logic [63:0] load_buf_q, load_buf_d;
  mem_out_t    out_q, out_d;
  logic        mem_op;
  logic [63:0] load_ext;
  logic [63:0] wb_sel;

  assign mem_op    = exu_valid & (exu_load_en | exu_store_en);
  assign mem_busy  = (state_q == MEM_IDLE && mem_op) || state_q == MEM_REQ || state_q == MEM_WAIT;
  assign dmem_req  = (state_q == MEM_REQ);
  assign dmem_we   = exu_store_en;
  assign dmem_addr = {exu_alu_result[63:3], 3'b000};

  lsu_align u_align (
    .funct3 (exu_funct3),
    .off    (exu_alu_result[2:0]),
    .rs2    (exu_data_rs2),
    .rdata  (dmem_rdata),
    .wmask  (dmem_wmask),
    .wdata  (dmem_wdata),
    .ldata  (load_ext)
  );

  always_comb begin
    state_d    = state_q;
    load_buf_d = load_buf_q;
    case (state_q)
      MEM_IDLE: if (mem_op) state_d = MEM_REQ;
      MEM_REQ:  if (dmem_ready) state_d = exu_store_en ? MEM_DONE : MEM_WAIT;
      MEM_WAIT: begin
        if (dmem_rvalid) begin
          state_d    = MEM_DONE;
          load_buf_d = load_ext;
        end
      end
      MEM_DONE: if (update) state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    wb_sel = exu_alu_result;
    if (exu_load_en)        wb_sel = load_buf_q;
    else if (exu_wb_spc_en) wb_sel = exu_snxt_pc;
  end

  // Busy wins over update so the stage emits bubbles while an access is in flight.
  always_comb begin
    out_d = out_q;
    if (mem_busy) begin
      out_d = '0;
    end else if (update) begin
      out_d.valid     = exu_valid;
      out_d.wb_en     = exu_wb_en;
      out_d.ebreak_en = exu_ebreak_en;
      out_d.wb_data   = wb_sel;
      out_d.index_rd  = exu_index_rd;
      out_d.pc        = exu_pc;
      out_d.instr     = exu_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= MEM_IDLE;
      load_buf_q <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_buf_q <= load_buf_d;
      out_q      <= out_d;
    end
  end

  assign mem_valid     = out_q.valid;
  assign mem_wb_en     = out_q.wb_en;
  assign mem_ebreak_en = out_q.ebreak_en;
  assign mem_wb_data   = out_q.wb_data;
  assign mem_index_rd  = out_q.index_rd;
  assign mem_pc        = out_q.pc;
  assign mem_instr     = out_q.instr;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a byte-level reference model
module tb_mem_stage;

  logic        clk, rstn, update;
  logic        exu_valid, exu_load_en, exu_store_en, exu_wb_en, exu_wb_spc_en, exu_ebreak_en;
  logic [2:0]  exu_funct3;
  logic [63:0] exu_alu_result, exu_data_rs2, exu_snxt_pc, exu_pc;
  logic [4:0]  exu_index_rd;
  logic [31:0] exu_instr;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;
  logic        mem_busy, mem_wb_en, mem_valid, mem_ebreak_en;
  logic [63:0] mem_wb_data, mem_pc;
  logic [4:0]  mem_index_rd;
  logic [31:0] mem_instr;

  int errors = 0;
  int checks = 0;
  logic [63:0] lbuf_model = 64'd0;

  typedef struct {
    bit        valid, load, store, wb, spc, ebrk;
    bit [2:0]  f3;
    bit [63:0] alu, rs2, snxt, pc;
    bit [4:0]  rd;
    bit [31:0] instr;
  } op_t;

  mem_stage dut (
    .clk(clk), .rstn(rstn), .update(update),
    .exu_valid(exu_valid), .exu_load_en(exu_load_en), .exu_store_en(exu_store_en),
    .exu_wb_en(exu_wb_en), .exu_wb_spc_en(exu_wb_spc_en), .exu_ebreak_en(exu_ebreak_en),
    .exu_funct3(exu_funct3), .exu_alu_result(exu_alu_result), .exu_data_rs2(exu_data_rs2),
    .exu_snxt_pc(exu_snxt_pc), .exu_index_rd(exu_index_rd), .exu_pc(exu_pc), .exu_instr(exu_instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_busy(mem_busy), .mem_wb_en(mem_wb_en), .mem_valid(mem_valid),
    .mem_ebreak_en(mem_ebreak_en), .mem_wb_data(mem_wb_data), .mem_index_rd(mem_index_rd),
    .mem_pc(mem_pc), .mem_instr(mem_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int size_of(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [7:0] model_mask(input bit [2:0] f3, input int off);
    logic [7:0] m = '0;
    for (int b = 0; b < 8; b++) if (b >= off && b < off + size_of(f3)) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input bit [2:0] f3, input logic [63:0] rs2);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = rs2[(b % size_of(f3))*8 +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input bit [2:0] f3, input int off, input logic [63:0] rd);
    logic [63:0] v = '0;
    int sz = size_of(f3);
    for (int k = 0; k < sz; k++) if (off + k < 8) v[k*8 +: 8] = rd[(off+k)*8 +: 8];
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    return v;
  endfunction

  function automatic logic [63:0] model_wb(input op_t o);
    if (o.load) return lbuf_model;
    if (o.spc)  return o.snxt;
    return o.alu;
  endfunction

  task automatic drive(input op_t o);
    exu_valid = o.valid; exu_load_en = o.load; exu_store_en = o.store;
    exu_wb_en = o.wb; exu_wb_spc_en = o.spc; exu_ebreak_en = o.ebrk;
    exu_funct3 = o.f3; exu_alu_result = o.alu; exu_data_rs2 = o.rs2;
    exu_snxt_pc = o.snxt; exu_index_rd = o.rd; exu_pc = o.pc; exu_instr = o.instr;
  endtask

  task automatic chk_out(input string tag, input op_t o);
    chk({tag, "_wb_data"}, mem_wb_data, model_wb(o));
    chk({tag, "_rd"}, mem_index_rd, o.rd);
    chk({tag, "_wb_en"}, mem_wb_en, o.wb);
    chk({tag, "_valid"}, mem_valid, o.valid);
    chk({tag, "_ebreak"}, mem_ebreak_en, o.ebrk);
    chk({tag, "_pc"}, mem_pc, o.pc);
    chk({tag, "_instr"}, mem_instr, o.instr);
  endtask

  task automatic run_alu(input string tag, input op_t o);
    drive(o);
    update = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    #1;
    chk({tag, "_busy"}, mem_busy, 1'b0);
    chk({tag, "_req"}, dmem_req, 1'b0);
    tick();
    chk_out(tag, o);
  endtask

  task automatic run_mem(input string tag, input op_t o, input int rdly, input int vdly,
                         input int hold, input logic [63:0] rdata);
    int busy_cycles = 0;
    int exp_busy = 2 + rdly + (o.load ? vdly + 1 : 0);
    int off = int'(o.alu[2:0]);
    drive(o);
    update = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    #1;
    busy_cycles += int'(mem_busy);
    chk({tag, "_idle_req"}, dmem_req, 1'b0);
    tick();
    for (int i = 0; i <= rdly; i++) begin
      dmem_ready = (i == rdly);
      #1;
      busy_cycles += int'(mem_busy);
      chk({tag, "_req"}, dmem_req, 1'b1);
      chk({tag, "_addr"}, dmem_addr, {o.alu[63:3], 3'b000});
      chk({tag, "_we"}, dmem_we, o.store);
      chk({tag, "_wmask"}, dmem_wmask, model_mask(o.f3, off));
      if (o.store) chk({tag, "_wdata"}, dmem_wdata, model_wdata(o.f3, o.rs2));
      chk({tag, "_bubble"}, mem_valid, 1'b0);
      tick();
    end
    dmem_ready = 1'b0;
    if (o.load) begin
      for (int j = 0; j <= vdly; j++) begin
        dmem_rvalid = (j == vdly);
        dmem_rdata  = (j == vdly) ? rdata : {$urandom, $urandom};
        #1;
        busy_cycles += int'(mem_busy);
        chk({tag, "_wait_req"}, dmem_req, 1'b0);
        tick();
      end
      lbuf_model = model_load(o.f3, off, rdata);
    end
    for (int h = 0; h < hold; h++) begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = {$urandom, $urandom};
      #1;
      chk({tag, "_hold_busy"}, mem_busy, 1'b0);
      chk({tag, "_hold_req"}, dmem_req, 1'b0);
      tick();
      chk({tag, "_hold_out"}, mem_valid, 1'b0);
    end
    dmem_rvalid = 1'b0;
    update = 1'b1;
    #1;
    chk({tag, "_done_busy"}, mem_busy, 1'b0);
    chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    tick();
    chk_out(tag, o);
  endtask

  function automatic op_t blank_op();
    op_t o;
    o.valid = 1'b1; o.load = 1'b0; o.store = 1'b0; o.wb = 1'b1; o.spc = 1'b0; o.ebrk = 1'b0;
    o.f3 = 3'b000; o.alu = '0; o.rs2 = '0; o.snxt = '0; o.rd = '0; o.pc = 64'h80000000;
    o.instr = 32'h00000013;
    return o;
  endfunction

  function automatic op_t rand_op(input bit is_mem);
    op_t o = blank_op();
    o.alu   = {$urandom, $urandom};
    o.rs2   = {$urandom, $urandom};
    o.snxt  = {$urandom, $urandom};
    o.pc    = {$urandom, $urandom};
    o.rd    = 5'($urandom);
    o.instr = $urandom;
    o.ebrk  = ($urandom_range(0, 7) == 0);
    o.spc   = $urandom_range(0, 1) == 1;
    if (is_mem) begin
      o.load  = $urandom_range(0, 1) == 1;
      o.store = !o.load;
      o.wb    = o.load;
      o.f3    = o.load ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
    end else begin
      o.wb    = $urandom_range(0, 1) == 1;
      // An invalid op carrying a load flag exposes the retained load buffer.
      o.valid = $urandom_range(0, 3) != 0;
      o.load  = !o.valid && ($urandom_range(0, 1) == 1);
    end
    return o;
  endfunction

  initial begin
    op_t o;
    rstn = 1'b0; update = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    drive(blank_op());
    exu_valid = 1'b0;
    tick();
    tick();
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_wb_data", mem_wb_data, 64'd0);
    chk("rst_pc", mem_pc, 64'd0);
    chk("rst_instr", mem_instr, 32'd0);
    rstn = 1'b1;

    o = blank_op(); o.alu = 64'h1234; o.rd = 5'd5;
    run_alu("alu", o);
    chk("alu_lit", mem_wb_data, 64'h1234);

    o = blank_op(); o.spc = 1'b1; o.snxt = 64'h80000008; o.alu = 64'h80000100; o.rd = 5'd1;
    run_alu("jal", o);
    chk("jal_lit", mem_wb_data, 64'h80000008);

    o = blank_op(); o.store = 1'b1; o.wb = 1'b0; o.f3 = 3'b000; o.alu = 64'h80000013; o.rs2 = 64'hAB;
    run_mem("sb", o, 0, 0, 0, 64'd0);
    chk("sb_wb_en_lit", mem_wb_en, 1'b0);

    o = blank_op(); o.load = 1'b1; o.f3 = 3'b000; o.alu = 64'h80000006; o.rd = 5'd7;
    run_mem("lb", o, 2, 0, 0, 64'h0080000000000000);
    chk("lb_lit", mem_wb_data, 64'hFFFFFFFFFFFFFF80);

    o.f3 = 3'b100;
    run_mem("lbu", o, 2, 0, 0, 64'h0080000000000000);
    chk("lbu_lit", mem_wb_data, 64'h80);

    o = blank_op(); o.load = 1'b1; o.f3 = 3'b010; o.alu = 64'h80000104; o.rd = 5'd9;
    run_mem("lw", o, 0, 0, 2, 64'h8000000100000000);
    chk("lw_lit", mem_wb_data, 64'hFFFFFFFF80000001);

    o.f3 = 3'b110;
    run_mem("lwu", o, 1, 2, 0, 64'h8000000100000000);
    chk("lwu_lit", mem_wb_data, 64'h0000000080000001);

    o = blank_op(); o.load = 1'b1; o.f3 = 3'b011; o.alu = 64'h80000200;
    drive(o);
    update = 1'b0;
    tick();
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("rstw_busy", mem_busy, 1'b1);
    rstn = 1'b0; exu_valid = 1'b0;
    tick();
    lbuf_model = 64'd0;
    chk("rstw_req", dmem_req, 1'b0);
    chk("rstw_busy_after", mem_busy, 1'b0);
    chk("rstw_valid", mem_valid, 1'b0);
    chk("rstw_wb_data", mem_wb_data, 64'd0);
    chk("rstw_rd", mem_index_rd, 5'd0);
    rstn = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'hDEADBEEFCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    chk("rstw_stray_req", dmem_req, 1'b0);
    o = blank_op(); o.valid = 1'b0; o.load = 1'b1; o.rd = 5'd3;
    run_alu("rstw_lbuf", o);
    chk("rstw_lbuf_lit", mem_wb_data, 64'd0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0)
        run_mem("rnd_mem", rand_op(1'b1), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0, {$urandom, $urandom});
      else
        run_alu("rnd_alu", rand_op(1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
